// File: rtl/sopc_2_pio_pkg.sv
// Shared definitions for the SOPC parallel I/O ports: register map and
// edge-capture encodings used by both input and output ports.
package sopc_2_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/sopc_2_sync_edge.sv
// Input synchronizer plus one-cycle edge detector for a parallel bus.
// sync_o is the metastability-hardened level; edge_o pulses for one cycle
// on each qualifying transition of sync_o.
module sopc_2_sync_edge
  import sopc_2_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o
);

  // sync_q[0] is the first (possibly metastable) stage; the last stage is used.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;

  assign sync_o = sync_q[SYNC_STAGES-1];

  // Shift the external bus through the synchronizer chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
  end

  // Previous synchronized level; resets low so a high input reads as a rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_q <= '0;
    else          prev_q <= sync_o;
  end

  // Edge qualifier selected at elaboration time.
  always_comb begin
    edge_o = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_o = sync_o & ~prev_q;
      EDGE_FALL: edge_o = ~sync_o & prev_q;
      default:   edge_o = sync_o ^ prev_q;
    endcase
  end

endmodule

// File: rtl/sopc_2_entrada_edge.sv
// Avalon-MM input PIO: synchronized level read, sticky per-bit edge capture
// with write-1-to-clear, and a maskable level interrupt.
module sopc_2_entrada_edge
  import sopc_2_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync, edge_det;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr;
  logic             unused_wd;

  // Upper write-data bits beyond WIDTH are intentionally ignored.
  assign unused_wd = ^(writedata >> WIDTH);

  sopc_2_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .in_i   (in_port),
    .sync_o (sync),
    .edge_o (edge_det)
  );

  assign wr = chipselect && !write_n;

  // Next-state for mask and capture; a new edge beats a same-cycle clear.
  always_comb begin
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr && address == ADDR_IRQMASK) irqmask_d = writedata[WIDTH-1:0];
    if (wr && address == ADDR_EDGECAP) edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    edgecap_d = edgecap_d | edge_det;
  end

  // Read mux is sampled every cycle; chipselect does not gate it.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d = 32'(sync);
      ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
      ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
      default:      readdata_d = '0;
    endcase
  end

  // Register file and read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_sopc_2_entrada_edge.sv
// Self-checking bench for sopc_2_entrada_edge: directed register-map
// scenarios followed by randomized traffic against a behavioural model.
module tb_sopc_2_entrada_edge;

  localparam int W  = 8;
  localparam int ET = 0;
  localparam int S  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [W-1:0] in_port = '0;
  logic [31:0] readdata;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;

  sopc_2_entrada_edge #(.WIDTH(W), .EDGE_TYPE(ET), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // ---- behavioural model ----
  // hist[k] = in_port value sampled k edges ago; the DATA register shows the
  // value from S-1 edges ago, and edges compare it with the one from S ago.
  logic [W-1:0] hist [0:S];
  logic [W-1:0] m_mask, m_cap;
  logic [31:0]  m_rd;

  always @(posedge clk or negedge reset_n) begin
    logic [W-1:0] lvl, old, ev, clr;
    if (!reset_n) begin
      for (int i = 0; i <= S; i++) hist[i] = '0;
      m_mask = '0; m_cap = '0; m_rd = '0;
    end else begin
      lvl = hist[S-1];
      old = hist[S];
      if (ET == 0)      ev = lvl & ~old;
      else if (ET == 1) ev = ~lvl & old;
      else              ev = lvl ^ old;
      if (address == 2'd0)      m_rd = 32'(lvl);
      else if (address == 2'd2) m_rd = 32'(m_mask);
      else if (address == 2'd3) m_rd = 32'(m_cap);
      else                      m_rd = 32'd0;
      clr = '0;
      if (chipselect && !write_n) begin
        if (address == 2'd2) m_mask = writedata[W-1:0];
        if (address == 2'd3) clr = writedata[W-1:0];
      end
      m_cap = (m_cap & ~clr) | ev;
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = in_port;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Every cycle: DUT outputs must match the model (inputs change later).
  always @(negedge clk) begin
    check("model_readdata", readdata, m_rd);
    check("model_irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
  end

  // Stimulus changes 1ns after the falling edge so sampling sees stable values.
  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  logic [31:0] d;

  initial begin
    // Reset with inputs low.
    tick(3);
    reset_n = 1'b1;
    rd(2'd0, d); check("reset_data", d, 32'h0);
    rd(2'd2, d); check("reset_mask", d, 32'h0);
    rd(2'd3, d); check("reset_cap", d, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'd0);

    // Level read; DATA ignores writes.
    in_port = 8'hA5;
    tick(3);
    rd(2'd0, d); check("level_a5", d, 32'h000000A5);
    wr(2'd0, 32'hFF);
    rd(2'd0, d); check("level_after_wr", d, 32'h000000A5);

    // Clear captures from the A5 step before edge tests.
    in_port = 8'h00;
    tick(4);
    wr(2'd3, 32'hFF);
    rd(2'd3, d); check("cap_cleared", d, 32'h0);

    // Rising capture with mask bit0.
    wr(2'd2, 32'h01);
    in_port = 8'h01;
    tick(4);
    rd(2'd3, d); check("cap_bit0", d, 32'h01);
    check("irq_bit0", {31'd0, irq}, 32'd1);
    in_port = 8'h03;
    tick(4);
    rd(2'd3, d); check("cap_bit1", d, 32'h03);
    check("irq_still", {31'd0, irq}, 32'd1);

    // Write-1-to-clear.
    wr(2'd3, 32'h01);
    rd(2'd3, d); check("w1c_bit0", d, 32'h02);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    wr(2'd3, 32'h00);
    rd(2'd3, d); check("w1c_zero", d, 32'h02);

    // Edge on bit2 captured on the same edge as a clear of bit2.
    in_port = 8'h07;
    tick(2);
    wr(2'd3, 32'h04);
    rd(2'd3, d); check("set_wins", d & 32'h04, 32'h04);

    // Fill capture and mask, then async reset between edges.
    in_port = 8'h00;
    tick(4);
    in_port = 8'hFF;
    tick(4);
    wr(2'd2, 32'hFF);
    rd(2'd3, d); check("cap_full", d, 32'hFF);
    check("irq_full", {31'd0, irq}, 32'd1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    in_port = 8'h00;
    #1;
    check("irq_async_reset", {31'd0, irq}, 32'd0);
    tick(2);
    reset_n = 1'b1;
    rd(2'd0, d); check("post_rst_data", d, 32'h0);
    rd(2'd2, d); check("post_rst_mask", d, 32'h0);
    rd(2'd3, d); check("post_rst_cap", d, 32'h0);

    // Randomized traffic, compared each cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 1) == 1);
      write_n    = ($urandom_range(0, 2) != 0);
      writedata  = $urandom;
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ W'($urandom);
      if ($urandom_range(0, 400) == 0) reset_n = 1'b0;
      else reset_n = 1'b1;
      tick();
    end
    reset_n = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
